// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/ack bus between the memory stage and data memory.
// Signals: dmem_req/we/addr/wdata/be (stage -> memory), dmem_ack/rdata (memory -> stage).
// Modports: master = memory stage (issues requests), slave = data memory (acknowledges).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Ports: clk/rst (sync, active-high); i_MEM_* from execute; o_MEM_stall back to execute;
// dmem (mem_stage_if.master) request/ack bus; o_MEM_* to write-back plus misalign/busErr pulses.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_MEM_valid,
  input  logic        i_MEM_regWe,
  input  logic        i_MEM_sWD,
  input  logic        i_MEM_dMemWe,
  input  logic [1:0]  i_MEM_size,
  input  logic        i_MEM_unsigned,
  input  logic [4:0]  i_MEM_WRA,
  input  logic [31:0] i_MEM_aluOut,
  input  logic [31:0] i_MEM_storeData,
  output logic        o_MEM_stall,
  mem_stage_if.master dmem,
  output logic        o_MEM_regWe,
  output logic        o_MEM_sWD,
  output logic [4:0]  o_MEM_WRA,
  output logic [31:0] o_MEM_aluOut,
  output logic [31:0] o_MEM_dMemData,
  output logic        o_MEM_misalign,
  output logic        o_MEM_busErr
);

  // The counter only has to reach TIMEOUT-1.
  localparam int          CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        reg_we;
    logic        swd;
    logic        dmem_we;
    logic [1:0]  size;
    logic        unsgn;
    logic [4:0]  wra;
    logic [31:0] alu_out;
    logic [31:0] store_data;
  } stage_t;

  stage_t        r;
  stage_t        next_r;
  logic [0:0]    state;
  logic [0:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] wait_cycles;

  logic [1:0]  off;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        memop;
  logic        misaligned;
  logic        req;
  logic        timeout_hit;
  logic        stall;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [3:0]  be_raw;
  logic [31:0] wdata;

  always_comb begin
    next_r            = '0;
    next_r.valid      = i_MEM_valid;
    next_r.reg_we     = i_MEM_regWe;
    next_r.swd        = i_MEM_sWD;
    next_r.dmem_we    = i_MEM_dMemWe;
    next_r.size       = i_MEM_size;
    next_r.unsgn      = i_MEM_unsigned;
    next_r.wra        = i_MEM_WRA;
    next_r.alu_out    = i_MEM_aluOut;
    next_r.store_data = i_MEM_storeData;
  end

  assign off     = r.alu_out[1:0];
  assign is_byte = (r.size == 2'b00);
  assign is_half = (r.size == 2'b01);
  assign is_word = r.size[1];  // 11 behaves as a word access

  assign memop      = r.valid & (r.swd | r.dmem_we);
  assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign req        = memop & ~misaligned;

  // Cycles already spent with req high; zero whenever no access is outstanding.
  assign wait_cycles = (state == WAIT) ? cnt : '0;
  assign timeout_hit = (TIMEOUT != 0) & req & ~dmem.dmem_ack & (wait_cycles == LAST);
  assign stall       = req & ~dmem.dmem_ack & ~timeout_hit;

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE: if (stall) begin
        state_n = WAIT;
        cnt_n   = 1;
      end
      WAIT: if (stall) begin
        cnt_n = cnt + 1'b1;
      end else begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (!stall) r <= next_r;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Little-endian lane pick from the ack-cycle read data, then extension.
  always_comb begin
    lane_b = dmem.dmem_rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    ext    = dmem.dmem_rdata;
    if (is_byte)      ext = {{24{lane_b[7] & ~r.unsgn}}, lane_b};
    else if (is_half) ext = {{16{lane_h[15] & ~r.unsgn}}, lane_h};
  end

  // Stores replicate the datum on every lane; be selects the lanes written.
  always_comb begin
    be_raw = 4'b1111;
    wdata  = r.store_data;
    if (r.dmem_we) begin
      if (is_byte) begin
        be_raw = 4'b0001 << off;
        wdata  = {4{r.store_data[7:0]}};
      end else if (is_half) begin
        be_raw = 4'b0011 << off;
        wdata  = {2{r.store_data[15:0]}};
      end
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = r.dmem_we & req;
  assign dmem.dmem_addr  = {r.alu_out[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata;
  assign dmem.dmem_be    = req ? be_raw : 4'b0000;

  assign o_MEM_stall    = stall;
  assign o_MEM_misalign = memop & misaligned;
  assign o_MEM_busErr   = timeout_hit;
  assign o_MEM_regWe    = r.valid & r.reg_we & ~stall & ~o_MEM_misalign & ~timeout_hit;
  assign o_MEM_sWD      = r.swd;
  assign o_MEM_WRA      = r.wra;
  assign o_MEM_aluOut   = r.alu_out;
  assign o_MEM_dMemData = (r.swd & ~r.dmem_we & req & dmem.dmem_ack) ? ext : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid, reg_we, swd, dmem_we, uns;
  logic [1:0]  size;
  logic [4:0]  wra;
  logic [31:0] alu, sd;
  logic        o_stall, o_reg_we, o_swd, o_mis, o_berr;
  logic [4:0]  o_wra;
  logic [31:0] o_alu, o_data;

  mem_stage_if dmem_bus();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_MEM_valid(valid), .i_MEM_regWe(reg_we), .i_MEM_sWD(swd), .i_MEM_dMemWe(dmem_we),
    .i_MEM_size(size), .i_MEM_unsigned(uns), .i_MEM_WRA(wra), .i_MEM_aluOut(alu),
    .i_MEM_storeData(sd), .o_MEM_stall(o_stall), .dmem(dmem_bus),
    .o_MEM_regWe(o_reg_we), .o_MEM_sWD(o_swd), .o_MEM_WRA(o_wra), .o_MEM_aluOut(o_alu),
    .o_MEM_dMemData(o_data), .o_MEM_misalign(o_mis), .o_MEM_busErr(o_berr)
  );

  typedef struct packed {
    logic        valid;
    logic        reg_we;
    logic        swd;
    logic        dmem_we;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  wra;
    logic [31:0] alu;
    logic [31:0] sd;
  } instr_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        stall;
    logic        reg_we;
    logic        mis;
    logic        berr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    instr_t      ins;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req_v);
    end
  endtask

  task automatic drive(input instr_t t);
    valid = t.valid; reg_we = t.reg_we; swd = t.swd; dmem_we = t.dmem_we;
    size = t.size; uns = t.uns; wra = t.wra; alu = t.alu; sd = t.sd;
  endtask

  // Reference: spec rules written as lane arithmetic on the stage contents.
  function automatic exp_t model(input instr_t r, input int waited, input logic ack,
                                 input logic [31:0] rd);
    exp_t e;
    int n;
    logic [31:0] off, v, m;
    logic memop, mis;
    e = '0;
    off = r.alu & 32'd3;
    n = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
    memop = r.valid && (r.swd || r.dmem_we);
    mis = (off % n) != 0;
    e.mis = memop && mis;
    e.req = memop && !mis;
    e.berr = e.req && !ack && (waited == TO - 1);
    e.stall = e.req && !ack && !e.berr;
    e.reg_we = r.valid && r.reg_we && !e.stall && !e.mis && !e.berr;
    if (e.req) begin
      e.addr = r.alu - off;
      e.we = r.dmem_we;
      m = r.dmem_we ? (((32'd1 << n) - 32'd1) << off) : 32'd15;
      e.be = m[3:0];
      e.wdata = (n == 1) ? {24'd0, r.sd[7:0]} * 32'h01010101 :
                (n == 2) ? {16'd0, r.sd[15:0]} * 32'h00010001 : r.sd;
      if (ack && r.swd && !r.dmem_we) begin
        if (n == 4) v = rd;
        else begin
          v = (rd >> (8 * off)) % (32'd1 << (8 * n));
          if (!r.uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        end
        e.data = v;
      end
    end
    return e;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    t = '0;
    t.valid = ($urandom_range(0, 9) != 0);
    case ($urandom_range(0, 2))
      1: t.swd = 1'b1;
      2: t.dmem_we = 1'b1;
      default: ;
    endcase
    t.reg_we = 1'($urandom_range(0, 1));
    t.size = 2'($urandom_range(0, 3));
    t.uns = 1'($urandom_range(0, 1));
    t.wra = 5'($urandom_range(0, 31));
    t.alu = $urandom;
    t.sd = $urandom;
    return t;
  endfunction

  function automatic vec_t mk(input logic s_wd, input logic d_we, input logic r_we,
                              input logic [1:0] sz, input logic un, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd,
                              input logic ereq, input logic emis, input logic [3:0] ebe,
                              input logic [31:0] eaddr, input logic [31:0] ewd,
                              input logic [31:0] edata, input logic erwe);
    vec_t v;
    v = '0;
    v.ins = '{valid: 1'b1, reg_we: r_we, swd: s_wd, dmem_we: d_we, size: sz, uns: un,
              wra: 5'd5, alu: a, sd: d};
    v.rdata = rd;
    v.e.req = ereq; v.e.we = d_we & ereq; v.e.mis = emis; v.e.be = ebe; v.e.addr = eaddr;
    v.e.wdata = ewd; v.e.data = edata; v.e.reg_we = erwe;
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".req"}, {31'd0, dmem_bus.dmem_req}, 0);
    chk({tag, ".we"}, {31'd0, dmem_bus.dmem_we}, 0);
    chk({tag, ".be"}, {28'd0, dmem_bus.dmem_be}, 0);
    chk({tag, ".addr"}, dmem_bus.dmem_addr, 0);
    chk({tag, ".wdata"}, dmem_bus.dmem_wdata, 0);
    chk({tag, ".stall"}, {31'd0, o_stall}, 0);
    chk({tag, ".regWe"}, {31'd0, o_reg_we}, 0);
    chk({tag, ".sWD"}, {31'd0, o_swd}, 0);
    chk({tag, ".WRA"}, {27'd0, o_wra}, 0);
    chk({tag, ".aluOut"}, o_alu, 0);
    chk({tag, ".data"}, o_data, 0);
    chk({tag, ".misalign"}, {31'd0, o_mis}, 0);
    chk({tag, ".busErr"}, {31'd0, o_berr}, 0);
  endtask

  vec_t   vt[14];
  instr_t idle, ld, mR, nxt;
  exp_t   e;
  int     mwait, lat;
  logic   ack;
  logic [31:0] rd;

  initial begin
    idle = '0;
    //         sWD dWe rWe sz   un  addr        sdata         rdata         req mis be      addr        wdata         data          rWe
    vt[0]  = mk(0, 0, 1, 2'd2, 0, 32'h1234,   32'h0,        32'h0,        0, 0, 4'h0, 32'h0,     32'h0,        32'h0,        1);
    vt[1]  = mk(1, 0, 1, 2'd0, 0, 32'h103,    32'h0,        32'h80AABBCC, 1, 0, 4'hF, 32'h100,   32'h0,        32'hFFFFFF80, 1);
    vt[2]  = mk(1, 0, 1, 2'd0, 1, 32'h103,    32'h0,        32'h80AABBCC, 1, 0, 4'hF, 32'h100,   32'h0,        32'h00000080, 1);
    vt[3]  = mk(1, 0, 1, 2'd1, 0, 32'h102,    32'h0,        32'h80AABBCC, 1, 0, 4'hF, 32'h100,   32'h0,        32'hFFFF80AA, 1);
    vt[4]  = mk(0, 1, 0, 2'd1, 0, 32'h202,    32'hBEEF,     32'h0,        1, 0, 4'hC, 32'h200,   32'hBEEFBEEF, 32'h0,        0);
    vt[5]  = mk(1, 0, 1, 2'd2, 0, 32'h101,    32'h0,        32'h0,        0, 1, 4'h0, 32'h0,     32'h0,        32'h0,        0);
    vt[6]  = mk(0, 1, 0, 2'd0, 0, 32'h201,    32'h5A,       32'h0,        1, 0, 4'h2, 32'h200,   32'h5A5A5A5A, 32'h0,        0);
    vt[7]  = mk(0, 1, 0, 2'd2, 0, 32'h300,    32'h11223344, 32'h0,        1, 0, 4'hF, 32'h300,   32'h11223344, 32'h0,        0);
    vt[8]  = mk(1, 0, 1, 2'd1, 1, 32'h100,    32'h0,        32'h1234F00D, 1, 0, 4'hF, 32'h100,   32'h0,        32'h0000F00D, 1);
    vt[9]  = mk(1, 0, 1, 2'd0, 0, 32'h101,    32'h0,        32'h80AABBCC, 1, 0, 4'hF, 32'h100,   32'h0,        32'hFFFFFFBB, 1);
    vt[10] = mk(1, 0, 1, 2'd3, 0, 32'h104,    32'h0,        32'hCAFEF00D, 1, 0, 4'hF, 32'h104,   32'h0,        32'hCAFEF00D, 1);
    vt[11] = mk(1, 0, 1, 2'd1, 0, 32'h103,    32'h0,        32'h0,        0, 1, 4'h0, 32'h0,     32'h0,        32'h0,        0);
    vt[12] = mk(0, 1, 0, 2'd3, 0, 32'h102,    32'h0,        32'h0,        0, 1, 4'h0, 32'h0,     32'h0,        32'h0,        0);
    vt[13] = mk(0, 1, 0, 2'd1, 0, 32'h201,    32'h1234,     32'h0,        0, 1, 4'h0, 32'h0,     32'h0,        32'h0,        0);

    ld = '{valid: 1'b1, reg_we: 1'b1, swd: 1'b1, dmem_we: 1'b0, size: 2'd2, uns: 1'b0,
           wra: 5'd7, alu: 32'h100, sd: 32'h0};

    // Reset with a live load on the inputs: everything must come out cleared.
    rst = 1'b1;
    drive(ld);
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    drive(idle);
    rst = 1'b0;
    #1;
    chk_zero("reset");
    dmem_bus.dmem_ack = 1'b0;

    // Single-instruction vectors with a zero-wait memory.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i].ins);
      dmem_bus.dmem_ack = 1'b0;
      @(negedge clk);
      drive(idle);
      dmem_bus.dmem_ack = vt[i].e.req;
      dmem_bus.dmem_rdata = vt[i].rdata;
      #1;
      chk($sformatf("vec%0d.req", i), {31'd0, dmem_bus.dmem_req}, {31'd0, vt[i].e.req});
      chk($sformatf("vec%0d.be", i), {28'd0, dmem_bus.dmem_be}, {28'd0, vt[i].e.be});
      chk($sformatf("vec%0d.stall", i), {31'd0, o_stall}, 0);
      chk($sformatf("vec%0d.misalign", i), {31'd0, o_mis}, {31'd0, vt[i].e.mis});
      chk($sformatf("vec%0d.busErr", i), {31'd0, o_berr}, 0);
      chk($sformatf("vec%0d.regWe", i), {31'd0, o_reg_we}, {31'd0, vt[i].e.reg_we});
      chk($sformatf("vec%0d.data", i), o_data, vt[i].e.data);
      chk($sformatf("vec%0d.WRA", i), {27'd0, o_wra}, 5);
      chk($sformatf("vec%0d.aluOut", i), o_alu, vt[i].ins.alu);
      if (vt[i].e.req) begin
        chk($sformatf("vec%0d.addr", i), dmem_bus.dmem_addr, vt[i].e.addr);
        chk($sformatf("vec%0d.we", i), {31'd0, dmem_bus.dmem_we}, {31'd0, vt[i].e.we});
        if (vt[i].ins.dmem_we)
          chk($sformatf("vec%0d.wdata", i), dmem_bus.dmem_wdata, vt[i].e.wdata);
      end
    end

    // Word load with ack held off for three cycles.
    @(negedge clk);
    drive(ld);
    dmem_bus.dmem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(idle);
      dmem_bus.dmem_ack = (k == 3);
      dmem_bus.dmem_rdata = 32'hDEADBEEF;
      #1;
      chk($sformatf("wait%0d.req", k), {31'd0, dmem_bus.dmem_req}, 1);
      chk($sformatf("wait%0d.stall", k), {31'd0, o_stall}, (k < 3) ? 1 : 0);
      chk($sformatf("wait%0d.regWe", k), {31'd0, o_reg_we}, (k == 3) ? 1 : 0);
      if (k == 3) chk("wait3.data", o_data, 32'hDEADBEEF);
    end
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0;
    #1;
    chk("wait.after.req", {31'd0, dmem_bus.dmem_req}, 0);

    // Memory never answers: time-out after TO request cycles.
    @(negedge clk);
    drive(ld);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      drive(idle);
      #1;
      chk($sformatf("to%0d.req", k), {31'd0, dmem_bus.dmem_req}, 1);
      chk($sformatf("to%0d.stall", k), {31'd0, o_stall}, (k < TO - 1) ? 1 : 0);
      chk($sformatf("to%0d.busErr", k), {31'd0, o_berr}, (k == TO - 1) ? 1 : 0);
      chk($sformatf("to%0d.regWe", k), {31'd0, o_reg_we}, 0);
    end
    @(negedge clk);
    #1;
    chk("to.after.req", {31'd0, dmem_bus.dmem_req}, 0);
    chk("to.after.busErr", {31'd0, o_berr}, 0);

    // Reset in the second WAIT cycle, then a late ack that must be ignored.
    @(negedge clk);
    drive(ld);
    @(negedge clk);
    drive(idle);
    #1;
    chk("rstw.stall", {31'd0, o_stall}, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h12345678;
    #1;
    chk_zero("rstw");
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0;

    // Random instruction stream against the reference model.
    mR = '0;
    mwait = 0;
    lat = 0;
    nxt = rnd();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive(nxt);
      e = model(mR, mwait, 1'b0, 32'h0);
      ack = e.req ? (mwait == lat) : ($urandom_range(0, 3) == 0);
      rd = $urandom;
      dmem_bus.dmem_ack = ack;
      dmem_bus.dmem_rdata = rd;
      e = model(mR, mwait, ack, rd);
      #1;
      chk("rand.req", {31'd0, dmem_bus.dmem_req}, {31'd0, e.req});
      chk("rand.stall", {31'd0, o_stall}, {31'd0, e.stall});
      chk("rand.be", {28'd0, dmem_bus.dmem_be}, {28'd0, e.be});
      chk("rand.regWe", {31'd0, o_reg_we}, {31'd0, e.reg_we});
      chk("rand.misalign", {31'd0, o_mis}, {31'd0, e.mis});
      chk("rand.busErr", {31'd0, o_berr}, {31'd0, e.berr});
      chk("rand.data", o_data, e.data);
      chk("rand.WRA", {27'd0, o_wra}, {27'd0, mR.wra});
      chk("rand.aluOut", o_alu, mR.alu);
      chk("rand.sWD", {31'd0, o_swd}, {31'd0, mR.swd});
      if (e.req) begin
        chk("rand.addr", dmem_bus.dmem_addr, e.addr);
        chk("rand.we", {31'd0, dmem_bus.dmem_we}, {31'd0, e.we});
        if (mR.dmem_we) chk("rand.wdata", dmem_bus.dmem_wdata, e.wdata);
      end
      if (!e.stall) begin
        mR = nxt;
        mwait = 0;
        lat = $urandom_range(0, 5);
        nxt = rnd();
      end else begin
        mwait++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between execute and write-back.
- Holds a stage register for the instruction leaving execute and performs its load/store on the data-memory request/ack bus, stalling upstream while the access is outstanding.
- Aligns and extends load data, and presents the result to the write-back stage.
- Flags misaligned accesses and memory time-outs, and retires them as bubbles.

Parameters:
- TIMEOUT, 16: maximum number of cycles req may stay high without ack before the access is aborted. 0 disables the time-out.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_MEM_valid  in  1  upstream slot holds a real instruction.
- i_MEM_regWe  in  1  register-file write enable.
- i_MEM_sWD  in  1  write-back source select; 1 = load data.
- i_MEM_dMemWe  in  1  store.
- i_MEM_size  in  2  access size: 00 byte, 01 half, 10 word.
- i_MEM_unsigned  in  1  zero-extend loads.
- i_MEM_WRA  in  5  destination register.
- i_MEM_aluOut  in  32  ALU result / effective address.
- i_MEM_storeData  in  32  store source data.
- o_MEM_stall  out  1  hold upstream and freeze this stage.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  write.
- o_dmem_addr  out  32  word address; bits [1:0] = 0.
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  access complete this cycle; rdata valid.
- i_dmem_rdata  in  32  read data.
- o_MEM_regWe  out  1  to write-back stage.
- o_MEM_sWD  out  1  to write-back stage.
- o_MEM_WRA  out  5  to write-back stage.
- o_MEM_aluOut  out  32  to write-back stage.
- o_MEM_dMemData  out  32  aligned, extended load data.
- o_MEM_misalign  out  1  one-cycle pulse: misaligned access dropped.
- o_MEM_busErr  out  1  one-cycle pulse: access timed out.

Behaviour:
- Stage register R captures all i_MEM_* on a clock edge when o_MEM_stall=0 and holds when it is 1. rst clears R, including valid, and the time-out counter. With R cleared, all outputs are 0.
- memop = R.valid & (R.sWD | R.dMemWe).
- Misaligned = half with addr[0]=1, or word with addr[1:0]≠0. Size 11 is treated as word.
- o_dmem_req = memop & ~misaligned (combinational from R). It is held until ack or time-out.
- While req is high, addr/we/wdata/be are stable and driven from R.
- Store data lanes:
  - byte: wdata = {4{d[7:0]}}, be = 0001 << addr[1:0].
  - half: wdata = {2{d[15:0]}}, be = 0011 << addr[1:0].
  - word: be = 1111.
  - Loads drive be = 1111.
- Load data is little-endian. The byte/half is selected by addr[1:0] from i_dmem_rdata in the ack cycle, then sign- or zero-extended to 32 bits per R.unsigned.
- FSM has two states:
  - IDLE: no outstanding access.
  - WAIT: req high and ack not yet seen. A counter counts WAIT cycles.
  - IDLE→WAIT when req=1 and ack=0.
  - WAIT→IDLE on ack, time-out, or rst.
- Zero-wait memory (ack in the first req cycle) causes no stall.
- o_MEM_stall = req & ~ack & ~timeout_hit.
- timeout_hit = (TIMEOUT≠0) & req & ~ack & (cycle count == TIMEOUT−1). With TIMEOUT=N, req stays high for at most N cycles.
- Retire cycle (stall=0): outputs = R fields, with o_MEM_dMemData = extended load data (0 for non-loads). The write-back stage captures them at the next edge while R advances.
- Bubble cases force o_MEM_regWe=0 (other outputs don't-care, driven from R):
  - any stall cycle;
  - a misaligned instruction, plus a misalign pulse that cycle, with no request issued;
  - a time-out cycle, plus a busErr pulse.
- R.valid=0 → regWe=0.
- Stores pass R.regWe through unchanged; the decoder guarantees it is 0.
- rst during WAIT: req drops in the cycle after the reset edge and no instruction retires. A late ack is ignored when req=0.
- ack when req=0 is ignored.

Test Plan:
- ALU op: regWe=1, WRA=5, aluOut=0x1234 → next cycle o_MEM_regWe=1, WRA=5, aluOut=0x1234; req never high; stall=0.
- Word load, addr 0x100, ack held off 3 cycles, rdata=0xDEADBEEF → req high 4 cycles; stall high 3 cycles with regWe=0; in the ack cycle dMemData=0xDEADBEEF, regWe=1.
- Byte load, addr 0x103, rdata=0x80AABBCC, unsigned=0 → 0xFFFFFF80. Same with unsigned=1 → 0x00000080. Half at 0x102 signed → 0xFFFF80AA.
- Half store 0xBEEF at addr 0x202 → wdata=0xBEEFBEEF, be=1100, we=1, addr=0x200, single-cycle ack, no stall.
- Word load at 0x101 → misalign pulse 1 cycle, req stays 0, regWe=0, next instruction proceeds.
- TIMEOUT=4, ack never → req high exactly 4 cycles, busErr pulse in 4th, stall 3 cycles. Also: rst in the 2nd WAIT cycle → req 0 after the reset edge and all outputs 0.
